bus_peripheral: RTL

Memory-mapped I/O responder on the external side of the CPU data bus. It answers the accesses the CPU issues on `CS`/`WR_RD`/`ADDR`/`Data_BUS_WRITE`, and returns `Data_BUS_READ` within the same cycle, because the CPU has no wait states. It holds a scratch register, a mailbox FIFO, a compare timer, and control/status registers, and raises an interrupt line. It is clocked by the same system clock as the CPU pipeline.

---
 rtl/bus_peripheral_if.sv | 31 +++
 rtl/bus_peripheral.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/bus_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_peripheral_if
// Purpose  : CPU external data-bus signal bundle (select, direction, address,
//            write data, read data) shared by the CPU side and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface bus_peripheral_if;
  logic        CS;
  logic        WR_RD;
  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic [31:0] Data_BUS_READ;

  modport master (
    output CS,
    output WR_RD,
    output ADDR,
    output Data_BUS_WRITE,
    input  Data_BUS_READ
  );

  modport slave (
    input  CS,
    input  WR_RD,
    input  ADDR,
    input  Data_BUS_WRITE,
    output Data_BUS_READ
  );
endinterface
`default_nettype wire

// File: rtl/bus_peripheral.sv
`default_nettype none
// ============================================================================
// Module   : bus_peripheral
// Purpose  : Zero-wait-state memory-mapped responder: scratch register,
//            mailbox FIFO, compare timer, control/status and an interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module bus_peripheral #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic             CLK,
  input  logic             Rst,
  bus_peripheral_if.slave  bus,
  output logic             IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [5:0] OFF_SCRATCH = 6'd0;
  localparam logic [5:0] OFF_FIFO    = 6'd1;
  localparam logic [5:0] OFF_STATUS  = 6'd2;
  localparam logic [5:0] OFF_CTRL    = 6'd3;
  localparam logic [5:0] OFF_TIMER   = 6'd4;
  localparam logic [5:0] OFF_COMPARE = 6'd5;

  // Architectural state
  logic [31:0]      scratch;
  logic [31:0]      timer;
  logic [31:0]      compare;
  logic [2:0]       ctrl;       // {irq_fifo_en, irq_match_en, timer_en}
  logic             ovf;
  logic             unf;
  logic             match;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Only the word offset is decoded; the remaining address bits are ignored.
  logic [5:0] offset;
  logic       unused_addr;
  assign offset      = bus.ADDR[7:2];
  assign unused_addr = ^{bus.ADDR[31:8], bus.ADDR[1:0]};

  logic acc_wr;
  logic acc_rd;
  assign acc_wr = bus.CS & bus.WR_RD;
  assign acc_rd = bus.CS & ~bus.WR_RD;

  logic wr_scratch, wr_ctrl, wr_timer, wr_compare;
  assign wr_scratch = acc_wr && (offset == OFF_SCRATCH);
  assign wr_ctrl    = acc_wr && (offset == OFF_CTRL);
  assign wr_timer   = acc_wr && (offset == OFF_TIMER);
  assign wr_compare = acc_wr && (offset == OFF_COMPARE);

  // Control-register strobes are never stored.
  logic clear_flags, flush;
  assign clear_flags = wr_ctrl & bus.Data_BUS_WRITE[3];
  assign flush       = wr_ctrl & bus.Data_BUS_WRITE[4];

  // FIFO request decode; a rejected push/pop only raises its sticky flag.
  logic fifo_empty, fifo_full;
  logic push_req, pop_req, do_push, do_pop, ovf_set, unf_set;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign push_req   = acc_wr && (offset == OFF_FIFO);
  assign pop_req    = acc_rd && (offset == OFF_FIFO);
  assign do_push    = push_req & ~fifo_full & ~flush;
  assign do_pop     = pop_req & ~fifo_empty & ~flush;
  assign ovf_set    = push_req & fifo_full;
  assign unf_set    = pop_req & fifo_empty;

  // Timer hit wraps to zero; a bus write to TIMER takes precedence over it.
  logic timer_hit, match_set;
  assign timer_hit = ctrl[0] && (timer == compare);
  assign match_set = timer_hit & ~wr_timer;

  logic [4:0]  count5;
  logic [31:0] status;
  assign count5 = 5'(count);
  assign status = {22'b0, count5, ovf, unf, fifo_full, fifo_empty, match};

  // Combinational read mux: zero unless this cycle is a read access.
  always_comb begin
    bus.Data_BUS_READ = '0;
    if (acc_rd) begin
      case (offset)
        OFF_SCRATCH: bus.Data_BUS_READ = scratch;
        OFF_FIFO:    bus.Data_BUS_READ = fifo_empty ? 32'd0 : mem[rd_ptr];
        OFF_STATUS:  bus.Data_BUS_READ = status;
        OFF_CTRL:    bus.Data_BUS_READ = {29'b0, ctrl};
        OFF_TIMER:   bus.Data_BUS_READ = timer;
        OFF_COMPARE: bus.Data_BUS_READ = compare;
        default:     bus.Data_BUS_READ = '0;
      endcase
    end
  end

  // Plain read/write registers.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      scratch <= '0;
      compare <= '0;
      ctrl    <= '0;
    end else begin
      if (wr_scratch) scratch <= bus.Data_BUS_WRITE;
      if (wr_compare) compare <= bus.Data_BUS_WRITE;
      if (wr_ctrl)    ctrl    <= bus.Data_BUS_WRITE[2:0];
    end
  end

  // Mailbox storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr] <= bus.Data_BUS_WRITE;
  end

  // Mailbox pointers and occupancy; flush clears everything.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (do_push) begin
      wr_ptr <= wr_ptr + 1'b1;
      count  <= count + 1'b1;
    end else if (do_pop) begin
      rd_ptr <= rd_ptr + 1'b1;
      count  <= count - 1'b1;
    end
  end

  // Free-running compare timer.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      timer <= '0;
    end else if (wr_timer) begin
      timer <= bus.Data_BUS_WRITE;
    end else if (timer_hit) begin
      timer <= '0;
    end else if (ctrl[0]) begin
      timer <= timer + 32'd1;
    end
  end

  // Sticky flags: a set event in the clearing cycle still leaves the flag set.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      ovf   <= 1'b0;
      unf   <= 1'b0;
      match <= 1'b0;
    end else begin
      ovf   <= (ovf   & ~clear_flags) | ovf_set;
      unf   <= (unf   & ~clear_flags) | unf_set;
      match <= (match & ~clear_flags) | match_set;
    end
  end

  // Interrupt is registered from the state left by the previous edge.
  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= (match & ctrl[1]) | (~fifo_empty & ctrl[2]);
    end
  end

endmodule
`default_nettype wire
